// File: rtl/prio_arbiter.sv
// Priority arbiter with registered grant outputs.
// The highest-priority requesting channel wins; ties are broken either by
// lowest index or round-robin from the last accepted grant. A committed
// grant is held stable until downstream accepts it. On acceptance the
// arbiter picks the next winner in the same cycle, so grants can issue
// back to back.
module prio_arbiter #(
  parameter int CH_NUM   = 8,
  parameter int PRI_W    = 8,
  parameter int TIE_MODE = 1,
  localparam int IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       req,
  input  logic [CH_NUM*PRI_W-1:0] priority_bus,
  input  logic                    grant_ready,
  output logic                    grant_valid,
  output logic [CH_NUM-1:0]       grant,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [PRI_W-1:0]        grant_pri
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state_r;
  state_t              next_state_s;

  logic [CH_NUM-1:0]   grant_r;
  logic [IDX_W-1:0]    grant_idx_r;
  logic [PRI_W-1:0]    grant_pri_r;
  logic [IDX_W-1:0]    last_idx_r;

  logic                any_req_s;
  logic                handshake_s;
  logic                load_s;
  logic                clear_s;

  logic [IDX_W-1:0]    ptr_s;
  int                  start_s;
  int                  chan_s;
  logic                found_s;
  logic [IDX_W-1:0]    best_idx_s;
  logic [PRI_W-1:0]    best_pri_s;
  logic [CH_NUM-1:0]   win_onehot_s;

  assign any_req_s = |req;

  // Pick the winner. The round-robin pointer is the just-accepted grant on a
  // handshake cycle, so that channel loses ties to every other tied channel.
  always_comb begin
    found_s    = 1'b0;
    best_idx_s = {IDX_W{1'b0}};
    best_pri_s = {PRI_W{1'b0}};
    chan_s     = 0;
    if ((state_r == ST_HOLD) && grant_ready) begin
      ptr_s = grant_idx_r;
    end else begin
      ptr_s = last_idx_r;
    end
    if (TIE_MODE == 1) begin
      start_s = int'(ptr_s) + 1;
      if (start_s >= CH_NUM) begin
        start_s = 0;
      end else begin
        start_s = start_s;
      end
    end else begin
      start_s = 0;
    end
    // Scan in tie-break order; strict '>' keeps the first channel found.
    for (int k = 0; k < CH_NUM; k++) begin
      chan_s = start_s + k;
      if (chan_s >= CH_NUM) begin
        chan_s = chan_s - CH_NUM;
      end else begin
        chan_s = chan_s;
      end
      if (req[chan_s] &&
          (!found_s || (priority_bus[chan_s*PRI_W +: PRI_W] > best_pri_s))) begin
        found_s    = 1'b1;
        best_idx_s = IDX_W'(chan_s);
        best_pri_s = priority_bus[chan_s*PRI_W +: PRI_W];
      end else begin
        found_s    = found_s;
      end
    end
    win_onehot_s = {{(CH_NUM-1){1'b0}}, 1'b1} << best_idx_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: IDLE waits for any request, HOLD leaves only when the
  // grant is accepted and nobody is requesting.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (grant_ready && !any_req_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Per-state control: when to capture a new winner, clear, or advance the pointer.
  always_comb begin
    handshake_s = 1'b0;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = any_req_s;
      end
      ST_HOLD: begin
        handshake_s = grant_ready;
        load_s      = grant_ready && any_req_s;
        clear_s     = grant_ready && !any_req_s;
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  // Grant registers and round-robin pointer; reset drops a held grant
  // without advancing the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r     <= {CH_NUM{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
      grant_pri_r <= {PRI_W{1'b0}};
      last_idx_r  <= IDX_W'(CH_NUM - 1);
    end else begin
      if (handshake_s) begin
        last_idx_r <= grant_idx_r;
      end
      if (load_s) begin
        grant_r     <= win_onehot_s;
        grant_idx_r <= best_idx_s;
        grant_pri_r <= best_pri_s;
      end else if (clear_s) begin
        grant_r     <= {CH_NUM{1'b0}};
        grant_idx_r <= {IDX_W{1'b0}};
        grant_pri_r <= {PRI_W{1'b0}};
      end
    end
  end

  assign grant_valid = (state_r == ST_HOLD);
  assign grant       = grant_r;
  assign grant_idx   = grant_idx_r;
  assign grant_pri   = grant_pri_r;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed self-checking bench for prio_arbiter. Two instances share the
// stimulus: dut1 uses round-robin tie-break, dut0 uses fixed lowest-index.
module tb_prio_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] priority_bus;
  logic        grant_ready;

  logic        gv1, gv0;
  logic [7:0]  g1, g0;
  logic [2:0]  gi1, gi0;
  logic [7:0]  gp1, gp0;

  int checks;
  int errors;

  prio_arbiter #(.CH_NUM(8), .PRI_W(8), .TIE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .priority_bus(priority_bus),
    .grant_ready(grant_ready), .grant_valid(gv1), .grant(g1),
    .grant_idx(gi1), .grant_pri(gp1)
  );

  prio_arbiter #(.CH_NUM(8), .PRI_W(8), .TIE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .priority_bus(priority_bus),
    .grant_ready(grant_ready), .grant_valid(gv0), .grant(g0),
    .grant_idx(gi0), .grant_pri(gp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_pri(input logic [7:0] v);
    for (int i = 0; i < 8; i++) priority_bus[i*8 +: 8] = v;
  endtask

  task automatic set_pri(input int ch, input logic [7:0] v);
    priority_bus[ch*8 +: 8] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 8'hFF; set_all_pri(8'd7); grant_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== 20'h0) begin
      errors++;
      $display("FAIL reset_rr: got %h expected %h", {gv1, g1, gi1, gp1}, 20'h0);
    end
    checks++;
    if ({gv0, g0, gi0, gp0} !== 20'h0) begin
      errors++;
      $display("FAIL reset_fixed: got %h expected %h", {gv0, g0, gi0, gp0}, 20'h0);
    end
    rst = 1'b0; req = 8'h00;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== 20'h0) begin
      errors++;
      $display("FAIL idle_no_req: got %h expected %h", {gv1, g1, gi1, gp1}, 20'h0);
    end
  endtask

  task automatic test_ignore_nonreq;
    set_all_pri(8'd200); set_pri(1, 8'd5); set_pri(5, 8'd9);
    req = 8'h22; grant_ready = 1'b0;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h20, 3'd5, 8'd9}) begin
      errors++;
      $display("FAIL ignore_nonreq: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h20, 3'd5, 8'd9});
    end
  endtask

  task automatic test_unsigned_rearb;
    // Handshake with new requests: re-arbitrate in the same cycle, 0x80 > 0x7F.
    req = 8'h03; set_pri(0, 8'h7F); set_pri(1, 8'h80); grant_ready = 1'b1;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h02, 3'd1, 8'h80}) begin
      errors++;
      $display("FAIL unsigned_rearb: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h02, 3'd1, 8'h80});
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== 20'h0) begin
      errors++;
      $display("FAIL drop_to_idle: got %h expected %h", {gv1, g1, gi1, gp1}, 20'h0);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_idx;
    logic [7:0] exp_onehot;
    rst = 1'b1; tick();
    rst = 1'b0; req = 8'hFF; set_all_pri(8'd7); grant_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      tick();
      exp_idx    = 3'(n % 8);
      exp_onehot = 8'h01 << exp_idx;
      checks++;
      if ({gv1, g1, gi1, gp1} !== {1'b1, exp_onehot, exp_idx, 8'd7}) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %h expected %h", n, {gv1, g1, gi1, gp1},
                 {1'b1, exp_onehot, exp_idx, 8'd7});
      end
      checks++;
      if ({gv0, g0, gi0, gp0} !== {1'b1, 8'h01, 3'd0, 8'd7}) begin
        errors++;
        $display("FAIL fixed_seq[%0d]: got %h expected %h", n, {gv0, g0, gi0, gp0},
                 {1'b1, 8'h01, 3'd0, 8'd7});
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_hold_stable;
    set_all_pri(8'd0); set_pri(3, 8'd4); req = 8'h08; grant_ready = 1'b0;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h08, 3'd3, 8'd4}) begin
      errors++;
      $display("FAIL hold_first: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h08, 3'd3, 8'd4});
    end
    req = 8'h40; set_pri(6, 8'd250);
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h08, 3'd3, 8'd4}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got %h expected %h", n, {gv1, g1, gi1, gp1},
                 {1'b1, 8'h08, 3'd3, 8'd4});
      end
    end
    grant_ready = 1'b1;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h40, 3'd6, 8'd250}) begin
      errors++;
      $display("FAIL hold_release: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h40, 3'd6, 8'd250});
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_single;
    set_all_pri(8'd0); set_pri(2, 8'd10); req = 8'h04; grant_ready = 1'b1;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h04, 3'd2, 8'd10}) begin
      errors++;
      $display("FAIL single_grant: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h04, 3'd2, 8'd10});
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== 20'h0) begin
      errors++;
      $display("FAIL single_idle: got %h expected %h", {gv1, g1, gi1, gp1}, 20'h0);
    end
  endtask

  task automatic test_reset_override;
    req = 8'hFF; set_all_pri(8'd7); grant_ready = 1'b0;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h08, 3'd3, 8'd7}) begin
      errors++;
      $display("FAIL pre_reset_grant: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h08, 3'd3, 8'd7});
    end
    rst = 1'b1; grant_ready = 1'b1;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== 20'h0) begin
      errors++;
      $display("FAIL reset_in_hs: got %h expected %h", {gv1, g1, gi1, gp1}, 20'h0);
    end
    rst = 1'b0; grant_ready = 1'b0;
    tick();
    checks++;
    if ({gv1, g1, gi1, gp1} !== {1'b1, 8'h01, 3'd0, 8'd7}) begin
      errors++;
      $display("FAIL post_reset_ch0: got %h expected %h", {gv1, g1, gi1, gp1},
               {1'b1, 8'h01, 3'd0, 8'd7});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 8'h00; priority_bus = 64'h0; grant_ready = 1'b0;
    test_reset();
    test_ignore_nonreq();
    test_unsigned_rearb();
    test_round_robin();
    test_hold_stable();
    test_single();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
